// File: rtl/tanimoto_cmp_array.sv
`default_nettype none
// ============================================================================
// Module   : tanimoto_cmp_array
// Brief    : Multi-lane Tanimoto threshold comparator. Each lane looks up a
//            threshold indexed by popcount(A)+popcount(B) and matches when
//            popcount(A&B) reaches it. LOAD/RUN/DRAIN mode control guards
//            table updates against in-flight beats.
// Options  : define TANIMOTO_CMP_STATS_EN to enable the saturating match
//            counter on o_MatchCnt (tied to zero otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module tanimoto_cmp_array #(
    parameter  int VECTOR_WIDTH = 35,
    parameter  int LANES        = 4,
    parameter  int ID_WIDTH     = 16,
    localparam int CNT_WIDTH    = $clog2(VECTOR_WIDTH + 1),
    localparam int SUM_WIDTH    = CNT_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES*CNT_WIDTH-1:0] i_CntA,
    input  logic [LANES*CNT_WIDTH-1:0] i_CntB,
    input  logic [LANES*CNT_WIDTH-1:0] i_CntC,
    input  logic [ID_WIDTH-1:0]        i_Id,
    input  logic                       i_Valid,
    output logic                       o_Ready,
    output logic [LANES-1:0]           o_Match,
    output logic [ID_WIDTH-1:0]        o_Id,
    output logic                       o_Valid,
    input  logic                       i_Ready,
    input  logic                       i_ThrWrEn,
    input  logic [SUM_WIDTH-1:0]       i_ThrAddr,
    input  logic [SUM_WIDTH-1:0]       i_ThrDin,
    input  logic                       i_Run,
    input  logic                       i_Load,
    output logic [1:0]                 o_Mode,
    output logic                       o_RangeErr,
    output logic [31:0]                o_MatchCnt
);

    localparam int                   c_TBL_DEPTH   = 2 * VECTOR_WIDTH + 1;
    localparam logic [SUM_WIDTH-1:0] c_TBL_DEPTH_S = SUM_WIDTH'(c_TBL_DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX     = CNT_WIDTH'(VECTOR_WIDTH);

    localparam logic [1:0] c_MODE_LOAD  = 2'b00;
    localparam logic [1:0] c_MODE_RUN   = 2'b01;
    localparam logic [1:0] c_MODE_DRAIN = 2'b10;

    logic [1:0]                 r_mode;
    logic                       r_range_err;
    logic [SUM_WIDTH-1:0]       r_thr_mem [c_TBL_DEPTH];

    logic                       r_s0_valid;
    logic [LANES*CNT_WIDTH-1:0] r_s0_a;
    logic [LANES*CNT_WIDTH-1:0] r_s0_b;
    logic [LANES*CNT_WIDTH-1:0] r_s0_c;
    logic [ID_WIDTH-1:0]        r_s0_id;

    logic                       r_s1_valid;
    logic [LANES*CNT_WIDTH-1:0] r_s1_c;
    logic [LANES-1:0]           r_s1_rerr;
    logic [ID_WIDTH-1:0]        r_s1_id;

    logic                       r_out_valid;
    logic [LANES-1:0]           r_out_match;
    logic [ID_WIDTH-1:0]        r_out_id;

    logic                       w_advance;
    logic                       w_accept;
    logic                       w_empty;
    logic [LANES-1:0]           w_rerr;
    logic [LANES-1:0]           w_match;

    // Whole pipeline moves together; it only freezes on a blocked output.
    assign w_advance = !r_out_valid || i_Ready;
    assign o_Ready   = (r_mode == c_MODE_RUN) && w_advance;
    assign w_accept  = i_Valid && o_Ready;
    assign w_empty   = !r_s0_valid && !r_s1_valid && !r_out_valid;

    assign o_Valid    = r_out_valid;
    assign o_Match    = r_out_match;
    assign o_Id       = r_out_id;
    assign o_Mode     = r_mode;
    assign o_RangeErr = r_range_err;

    // Threshold table writes, only honoured in LOAD and within the table.
    always_ff @(posedge clk) begin
        if (r_mode == c_MODE_LOAD && i_ThrWrEn && i_ThrAddr < c_TBL_DEPTH_S) begin
            r_thr_mem[i_ThrAddr] <= i_ThrDin;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [CNT_WIDTH-1:0] w_a;
        logic [CNT_WIDTH-1:0] w_b;
        logic [CNT_WIDTH-1:0] w_c;
        logic [CNT_WIDTH-1:0] w_s1_c;
        logic [SUM_WIDTH-1:0] w_sum;
        logic [SUM_WIDTH-1:0] w_addr;
        logic [SUM_WIDTH-1:0] r_thr_q;

        assign w_a    = r_s0_a[k*CNT_WIDTH +: CNT_WIDTH];
        assign w_b    = r_s0_b[k*CNT_WIDTH +: CNT_WIDTH];
        assign w_c    = r_s0_c[k*CNT_WIDTH +: CNT_WIDTH];
        assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
        assign w_rerr[k] = (w_a > c_CNT_MAX) || (w_b > c_CNT_MAX) || (w_c > c_CNT_MAX);
        // Out-of-range sums cannot match anyway; keep the read address legal.
        assign w_addr = (w_sum < c_TBL_DEPTH_S) ? w_sum : '0;

        // Synchronous table read for this lane, enabled with the pipeline.
        always_ff @(posedge clk) begin
            if (w_advance) begin
                r_thr_q <= r_thr_mem[w_addr];
            end
        end

        assign w_s1_c     = r_s1_c[k*CNT_WIDTH +: CNT_WIDTH];
        assign w_match[k] = !r_s1_rerr[k] && ({1'b0, w_s1_c} >= r_thr_q);
    end

    // Three-stage datapath: input capture, sum/lookup, compare into output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid  <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_match <= '0;
            r_out_id    <= '0;
            r_range_err <= 1'b0;
        end else if (w_advance) begin
            r_s0_valid  <= w_accept;
            r_s0_a      <= i_CntA;
            r_s0_b      <= i_CntB;
            r_s0_c      <= i_CntC;
            r_s0_id     <= i_Id;

            r_s1_valid  <= r_s0_valid;
            r_s1_c      <= r_s0_c;
            r_s1_rerr   <= w_rerr;
            r_s1_id     <= r_s0_id;

            r_out_valid <= r_s1_valid;
            r_out_match <= r_s1_valid ? w_match : '0;
            r_out_id    <= r_s1_id;

            if (r_s0_valid && (|w_rerr)) begin
                r_range_err <= 1'b1;
            end
        end
    end

    // Mode control; DRAIN returns to LOAD once every stage is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= c_MODE_LOAD;
        end else begin
            case (r_mode)
                c_MODE_LOAD:  if (i_Run)   r_mode <= c_MODE_RUN;
                c_MODE_RUN:   if (i_Load)  r_mode <= c_MODE_DRAIN;
                c_MODE_DRAIN: if (w_empty) r_mode <= c_MODE_LOAD;
                default:                   r_mode <= c_MODE_LOAD;
            endcase
        end
    end

`ifdef TANIMOTO_CMP_STATS_EN
    logic [31:0] r_match_cnt;
    logic [31:0] w_pop;
    logic [32:0] w_cnt_next;

    // Number of matching lanes in the current output beat.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + 32'(r_out_match[i]);
        end
    end

    assign w_cnt_next = {1'b0, r_match_cnt} + {1'b0, w_pop};

    // Saturating accumulation of matches on each consumed output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match_cnt <= '0;
        end else if (r_out_valid && i_Ready) begin
            r_match_cnt <= w_cnt_next[32] ? 32'hFFFF_FFFF : w_cnt_next[31:0];
        end
    end

    assign o_MatchCnt = r_match_cnt;
`else
    assign o_MatchCnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tanimoto_cmp_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_tanimoto_cmp_array
// Brief    : Directed scoreboard bench for tanimoto_cmp_array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tanimoto_cmp_array;

    localparam int VW = 35;

`ifdef TANIMOTO_CMP_STATS_EN
    localparam int c_STATS = 1;
`else
    localparam int c_STATS = 0;
`endif

    logic        clk;
    logic        rst;
    logic [23:0] cnt_a, cnt_b, cnt_c;
    logic [15:0] id_in, id_out;
    logic        valid_in, ready_out, valid_out, ready_in;
    logic [3:0]  match_out;
    logic        thr_we;
    logic [6:0]  thr_addr, thr_din;
    logic        run, load;
    logic [1:0]  mode;
    logic        range_err;
    logic [31:0] match_cnt;

    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  match;
    } exp_t;

    exp_t sb[$];
    int   thr_model[71];
    int   checks   = 0;
    int   failures = 0;
    int   consumed = 0;
    bit   last_acc = 0;

    tanimoto_cmp_array #(.VECTOR_WIDTH(35), .LANES(4), .ID_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_CntA     (cnt_a),
        .i_CntB     (cnt_b),
        .i_CntC     (cnt_c),
        .i_Id       (id_in),
        .i_Valid    (valid_in),
        .o_Ready    (ready_out),
        .o_Match    (match_out),
        .o_Id       (id_out),
        .o_Valid    (valid_out),
        .i_Ready    (ready_in),
        .i_ThrWrEn  (thr_we),
        .i_ThrAddr  (thr_addr),
        .i_ThrDin   (thr_din),
        .i_Run      (run),
        .i_Load     (load),
        .o_Mode     (mode),
        .o_RangeErr (range_err),
        .o_MatchCnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {6'(l3), 6'(l2), 6'(l1), 6'(l0)};
    endfunction

    // Reference: threshold lookup on the bench's own copy of the table.
    function automatic logic [3:0] model(input logic [23:0] a, input logic [23:0] b,
                                         input logic [23:0] c);
        logic [3:0] m;
        int ak, bk, ck;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            ak = int'(a[k*6 +: 6]);
            bk = int'(b[k*6 +: 6]);
            ck = int'(c[k*6 +: 6]);
            if (ak > VW || bk > VW || ck > VW) m[k] = 1'b0;
            else                               m[k] = (ck >= thr_model[ak + bk]);
        end
        return m;
    endfunction

    task automatic rand_beat();
        cnt_a = pk($urandom_range(0, 35), $urandom_range(0, 35), $urandom_range(0, 35), $urandom_range(0, 35));
        cnt_b = pk($urandom_range(0, 35), $urandom_range(0, 35), $urandom_range(0, 35), $urandom_range(0, 35));
        cnt_c = pk($urandom_range(0, 35), $urandom_range(0, 35), $urandom_range(0, 35), $urandom_range(0, 35));
    endtask

    // One clock: sample handshakes at negedge, score outputs, log accepts.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = (valid_in === 1'b1) && (ready_out === 1'b1);
        if (valid_out === 1'b1 && ready_in === 1'b1) begin
            consumed++;
            chk("sb_has_entry", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_id", 32'(id_out), 32'(e.id));
                chk("out_match", 32'(match_out), 32'(e.match));
            end
        end
        if (last_acc) sb.push_back({id_in, model(cnt_a, cnt_b, cnt_c)});
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int c0;
        int next_id;
        int cyc;

        rst = 1; cnt_a = 0; cnt_b = 0; cnt_c = 0; id_in = 0; valid_in = 0;
        ready_in = 1; thr_we = 0; thr_addr = 0; thr_din = 0; run = 0; load = 0;
        repeat (3) tick();

        // Reset state
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_ready", 32'(ready_out), 0);
        chk("rst_match", 32'(match_out), 0);
        chk("rst_id", 32'(id_out), 0);
        chk("rst_rangeerr", 32'(range_err), 0);
        chk("rst_matchcnt", match_cnt, 0);
        rst = 0;

        // Load thr[s] = s>>1
        for (int s = 0; s < 71; s++) begin
            thr_we = 1; thr_addr = 7'(s); thr_din = 7'(s >> 1);
            thr_model[s] = s >> 1;
            tick();
        end
        thr_we = 0;
        run = 1; tick(); run = 0;
        chk("mode_run", 32'(mode), 1);

        // Reference beat and 3-cycle latency
        cnt_a = pk(3, 6, 20, 33); cnt_b = pk(4, 8, 1, 2); cnt_c = pk(3, 6, 20, 35);
        id_in = 16'h00A5; valid_in = 1;
        #1 chk("ready_run", 32'(ready_out), 1);
        tick();
        chk("acc_ref", 32'(last_acc), 1);
        valid_in = 0;
        chk("lat_c1", 32'(valid_out), 0);
        tick();
        chk("lat_c2", 32'(valid_out), 0);
        tick();
        chk("lat_c3", 32'(valid_out), 1);
        chk("ref_match", 32'(match_out), 32'h0000_000D);
        chk("ref_id", 32'(id_out), 32'h0000_00A5);
        tick();

        // Stream 8 beats with output stall in cycles 3..7
        c0 = consumed; next_id = 1; cyc = 0;
        rand_beat();
        while ((next_id <= 8 || sb.size() > 0) && cyc < 60) begin
            ready_in = !(cyc >= 3 && cyc <= 7);
            valid_in = (next_id <= 8);
            id_in    = 16'(next_id);
            #1;
            if (!ready_in && valid_out === 1'b1) chk("ready_low_stall", 32'(ready_out), 0);
            tick();
            if (last_acc) begin
                next_id++;
                rand_beat();
            end
            cyc++;
        end
        valid_in = 0; ready_in = 1;
        chk("stream_sb_empty", 32'(sb.size()), 0);
        chk("stream_accepted", 32'(next_id), 9);
        chk("stream_delivered", 32'(consumed - c0), 8);

        // Out-of-range count on lane 2
        chk("rerr_before", 32'(range_err), 0);
        cnt_a = pk(10, 10, 10, 10); cnt_b = pk(10, 10, 10, 10); cnt_c = pk(12, 12, 36, 12);
        id_in = 16'h0037; valid_in = 1;
        tick();
        valid_in = 0;
        for (int i = 0; i < 10 && valid_out !== 1'b1; i++) tick();
        chk("rerr_out_valid", 32'(valid_out), 1);
        chk("rerr_match", 32'(match_out), 32'h0000_000B);
        tick();
        chk("rerr_set", 32'(range_err), 1);
        for (int i = 0; i < 4; i++) begin
            rand_beat(); id_in = 16'(16'h0040 + i); valid_in = 1; tick();
        end
        valid_in = 0;
        repeat (4) tick();
        chk("rerr_sticky", 32'(range_err), 1);

        // Drain with 3 beats in flight; RUN-mode write to thr[7] ignored
        thr_we = 1; thr_addr = 7'd7; thr_din = 7'd0;
        for (int i = 0; i < 3; i++) begin
            rand_beat(); id_in = 16'(16'h0100 + i); valid_in = 1;
            tick();
            chk("drain_fill_acc", 32'(last_acc), 1);
        end
        thr_we = 0; valid_in = 0;
        c0 = consumed;
        load = 1; tick(); load = 0;
        chk("mode_drain", 32'(mode), 2);
        rand_beat(); id_in = 16'h01FF; valid_in = 1;
        #1 chk("drain_ready", 32'(ready_out), 0);
        for (int i = 0; i < 12 && mode !== 2'b00; i++) tick();
        valid_in = 0;
        chk("drain_to_load", 32'(mode), 0);
        chk("drain_delivered", 32'(consumed - c0), 3);
        chk("drain_sb_empty", 32'(sb.size()), 0);

        // Reset with pipeline full
        run = 1; tick(); run = 0;
        ready_in = 0;
        for (int i = 0; i < 5; i++) begin
            rand_beat(); id_in = 16'(16'h0200 + i); valid_in = 1; tick();
        end
        chk("full_accepted", 32'(sb.size()), 3);
        chk("full_ready_low", 32'(ready_out), 0);
        rst = 1; valid_in = 0;
        tick();
        chk("rst_mid_valid", 32'(valid_out), 0);
        chk("rst_mid_mode", 32'(mode), 0);
        chk("rst_mid_matchcnt", match_cnt, 0);
        chk("rst_mid_rangeerr", 32'(range_err), 0);
        sb.delete();
        rst = 0; ready_in = 1;
        repeat (3) tick();
        chk("rst_no_ghost", 32'(valid_out), 0);

        // Run and Load together in LOAD: Run wins
        run = 1; load = 1; tick(); run = 0; load = 0;
        chk("both_in_load", 32'(mode), 1);

        // Table retained; thr[7] still 3
        cnt_a = pk(3, 35, 0, 10); cnt_b = pk(4, 35, 0, 11); cnt_c = pk(2, 35, 0, 5);
        id_in = 16'h0300; valid_in = 1;
        tick();
        valid_in = 0;
        for (int i = 0; i < 10 && valid_out !== 1'b1; i++) tick();
        chk("probe_valid", 32'(valid_out), 1);
        chk("probe_match", 32'(match_out), 32'h0000_0006);
        tick();

        // Run and Load together in RUN: Load wins
        run = 1; load = 1; tick(); run = 0; load = 0;
        chk("both_in_run", 32'(mode), 2);
        for (int i = 0; i < 12 && mode !== 2'b00; i++) tick();
        chk("both_back_load", 32'(mode), 0);

        // Statistics: reference beat 10 times after reset
        rst = 1; tick(); rst = 0;
        run = 1; tick(); run = 0;
        c0 = consumed;
        cnt_a = pk(3, 6, 20, 33); cnt_b = pk(4, 8, 1, 2); cnt_c = pk(3, 6, 20, 35);
        valid_in = 1;
        for (int i = 0; i < 10; i++) begin
            id_in = 16'(16'h0400 + i);
            tick();
        end
        valid_in = 0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        tick();
        chk("stats_delivered", 32'(consumed - c0), 10);
        chk("stats_matchcnt", match_cnt, (c_STATS != 0) ? 32'd30 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tanimoto_cmp_array.md
TANIMOTO_CMP_ARRAY -- requirements
Module: tanimoto_cmp_array

Interface
REQ-001 Parameter VECTOR_WIDTH, default 35, fingerprint bit count.
REQ-002 Parameter LANES, default 4, parallel comparison lanes.
REQ-003 Parameter ID_WIDTH, default 16, sideband tag width.
REQ-004 Derived: CNT_WIDTH = $clog2(VECTOR_WIDTH+1); SUM_WIDTH = CNT_WIDTH+1; table depth 2*VECTOR_WIDTH+1.
REQ-005 clk  in  1  single clock, all logic rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 i_CntA  in  LANES*CNT_WIDTH  popcount A per lane, lane 0 in LSBs.
REQ-008 i_CntB  in  LANES*CNT_WIDTH  popcount B per lane.
REQ-009 i_CntC  in  LANES*CNT_WIDTH  popcount (A AND B) per lane.
REQ-010 i_Id  in  ID_WIDTH  tag carried with the beat.
REQ-011 i_Valid / o_Ready  in/out  1  input handshake, beat accepted when both high.
REQ-012 o_Match  out  LANES  bit k = 1 when lane k passes threshold.
REQ-013 o_Id  out  ID_WIDTH  tag of the output beat.
REQ-014 o_Valid / i_Ready  out/in  1  output handshake, beat consumed when both high.
REQ-015 i_ThrWrEn, i_ThrAddr[SUM_WIDTH-1:0], i_ThrDin[SUM_WIDTH-1:0]  in  threshold table write port.
REQ-016 i_Run, i_Load  in  1  mode-change request pulses.
REQ-017 o_Mode  out  2  00 LOAD, 01 RUN, 10 DRAIN.
REQ-018 o_RangeErr  out  1  sticky out-of-range count flag.
REQ-019 o_MatchCnt  out  32  match statistics (see Configuration).

Function
REQ-020 Threshold table SHALL be synchronous RAM, depth 2*VECTOR_WIDTH+1, entry width SUM_WIDTH, shared read by all lanes.
REQ-021 Lane k SHALL match when CntC[k] >= thr[CntA[k]+CntB[k]], sum computed at SUM_WIDTH without truncation.
REQ-022 Pipeline: S0 input register, S1 sum + table read, S2 compare into output register; latency 3 cycles accept-to-o_Valid when i_Ready held high.
REQ-023 Throughput one beat per cycle; advance = !o_Valid || i_Ready; all stages, including table read enable, hold while not advancing.
REQ-024 o_Ready = (mode==RUN) && advance; beats never dropped, duplicated or reordered.
REQ-025 Any lane with CntA, CntB or CntC > VECTOR_WIDTH SHALL give match 0 for that lane and set o_RangeErr, cleared only by rst.
REQ-026 FSM LOAD: table writes accepted, o_Ready=0; i_Run -> RUN.
REQ-027 FSM RUN: table writes ignored; i_Load -> DRAIN; i_Run ignored.
REQ-028 FSM DRAIN: o_Ready=0, pipeline drains normally; when S0..S2 and output empty -> LOAD.
REQ-029 i_Run and i_Load asserted together: i_Load wins in RUN, i_Run wins in LOAD.
REQ-030 Table write with i_ThrAddr >= table depth SHALL be ignored.

Reset
REQ-031 On rst: mode LOAD, o_Valid=0, o_Match=0, o_Id=0, o_Ready=0, o_RangeErr=0, o_MatchCnt=0, all stage valids cleared; table contents retained.
REQ-032 rst mid-stream SHALL discard all in-flight beats; o_Valid low in the cycle after rst sampled.

Configuration
REQ-033 Macro TANIMOTO_CMP_STATS_EN defined: o_MatchCnt adds popcount(o_Match) on every output handshake, saturating at 2^32-1.
REQ-034 Macro undefined: counter logic absent, o_MatchCnt tied 0; all other behaviour identical.

Verification
REQ-035 VW=35, LANES=4, load thr[s]=s>>1 for s=0..70, i_Run; beat lanes (a,b,c)=(3,4,3),(6,8,6),(20,1,20),(33,2,35), id=0x00A5 -> o_Match=4'b1101, o_Id=0x00A5 exactly 3 cycles after accept.
REQ-036 Stream 8 beats ids 1..8, i_Ready low cycles 3-7 -> all 8 outputs, ids in order 1..8, no duplicates, o_Ready low while stalled and full.
REQ-037 Lane 2 with CntC=36 -> o_Match[2]=0, other lanes unaffected, o_RangeErr=1 and stays 1 until rst.
REQ-038 i_Load with 3 beats in flight -> o_Mode=DRAIN, 3 beats delivered, then o_Mode=LOAD; write to thr[7] issued during RUN has no effect.
REQ-039 rst asserted with pipeline full -> next cycle o_Valid=0, o_Mode=LOAD, o_MatchCnt=0; table still holds thr[s]=s>>1.
REQ-040 With TANIMOTO_CMP_STATS_EN, REQ-035 beat repeated 10 times -> o_MatchCnt=30; without macro o_MatchCnt=0.
